// File: rtl/demux_router.sv
// Registered, handshaked 1-to-N demultiplexer with broadcast mode.
// Each channel has a one-entry holding register; illegal selects are dropped.
module demux_router #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 6,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic [DATA_W-1:0]        in_data,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [SEL_W:0] LP_NCH = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]   r_full;
    logic [DATA_W-1:0] r_data [N_CH];
    logic              r_drop_pulse;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [N_CH-1:0]   w_free;
    logic [N_CH-1:0]   w_push;
    logic [N_CH-1:0]   w_pop;
    logic              w_legal;
    logic              w_in_ready;
    logic              w_drop;

    assign w_free  = ~r_full | out_ready;
    assign w_pop   = r_full & out_ready;
    assign w_legal = ({1'b0, in_sel} < LP_NCH);

    // in_ready must never depend on in_valid
    always_comb begin
        w_in_ready = 1'b1;
        w_push     = '0;
        w_drop     = 1'b0;
        if (in_bcast) begin
            w_in_ready = &w_free;
            if (in_valid && w_in_ready) begin
                w_push = '1;
            end
        end else if (w_legal) begin
            for (int k = 0; k < N_CH; k++) begin
                if (in_sel == SEL_W'(k)) begin
                    w_in_ready = w_free[k];
                    w_push[k]  = in_valid && w_free[k];
                end
            end
        end else begin
            w_drop = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full       <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            // a push in the same cycle as a pop keeps the channel full
            for (int k = 0; k < N_CH; k++) begin
                if (w_push[k]) begin
                    r_data[k] <= in_data;
                    r_full[k] <= 1'b1;
                end else if (w_pop[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = r_data[g];
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_full;
    assign drop_pulse = r_drop_pulse;
    assign drop_cnt   = r_drop_cnt;

endmodule
